// File: rtl/moon_motion_if.sv
// -----------------------------------------------------------------------------
// moon_motion_if
//   Groups the moon motion controller's control inputs and its
//   position/status outputs into one bundle.
//
//   Signal summary (direction as seen by the controller):
//     i_enable        in   1   run the attack pattern; low parks the moon in IDLE
//     i_player_x/y    in   10  player sprite centre (px)
//     i_speed_offset  in   26  subtracted from the base tick period
//     o_moon_x/y      out  10  moon centre, integer part of the Q10.10 position
//     o_state         out  2   0 IDLE, 1 COOLDOWN, 2 AIM, 3 DASH
//     o_on_border     out  1   moon sits on a playfield edge
//     o_dash_start    out  1   one-clk pulse when a dash begins
//     o_motion_tick   out  1   one-clk pulse per motion tick
//
//   Modports:
//     master - the side that drives the controls (game logic / testbench)
//     slave  - the moon motion controller
// -----------------------------------------------------------------------------
interface moon_motion_if;
  logic        i_enable;
  logic [9:0]  i_player_x;
  logic [9:0]  i_player_y;
  logic [25:0] i_speed_offset;
  logic [9:0]  o_moon_x;
  logic [9:0]  o_moon_y;
  logic [1:0]  o_state;
  logic        o_on_border;
  logic        o_dash_start;
  logic        o_motion_tick;

  modport master (
    output i_enable, i_player_x, i_player_y, i_speed_offset,
    input  o_moon_x, o_moon_y, o_state, o_on_border, o_dash_start, o_motion_tick
  );

  modport slave (
    input  i_enable, i_player_x, i_player_y, i_speed_offset,
    output o_moon_x, o_moon_y, o_state, o_on_border, o_dash_start, o_motion_tick
  );
endinterface

// File: rtl/moon_motion_ctrl.sv
// -----------------------------------------------------------------------------
// moon_motion_ctrl
//   Attack-pattern sequencer for the moon boss sprite:
//   home -> cooldown -> aim at player -> dash to border -> cooldown ...
//   Keeps the moon position in Q10.10 fixed point and runs its own
//   speed-scalable motion tick divider.
//
//   Ports:
//     i_clk    in   system clock
//     i_reset  in   synchronous, active-high reset (overrides everything)
//     bus      moon_motion_if.slave (controls in, position/status out)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | parked; position held, velocity zero
//   COOLDOWN | waiting DELAY_TICKS motion ticks before aiming
//   AIM      | single clk: sample player, compute dash velocity
//   DASH     | move by velocity each tick until border hit or timeout
// -----------------------------------------------------------------------------
module moon_motion_ctrl #(
  parameter int MAX_X          = 384,
  parameter int MAX_Y          = 448,
  parameter int HOME_X         = 192,
  parameter int HOME_Y         = 100,
  parameter int TICK_MAX       = 2_000_000,
  parameter int DELAY_TICKS    = 100,
  parameter int STEP_SHIFT     = 6,
  parameter int MAX_DASH_TICKS = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  moon_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_AIM      = 2'd2,
    ST_DASH     = 2'd3
  } state_t;

  localparam int VEL_SHIFT = 10 - STEP_SHIFT;

  localparam logic [25:0] TICK_PERIOD = 26'(TICK_MAX);
  localparam logic [25:0] TICK_SAT    = 26'(TICK_MAX - 1);

  localparam logic [19:0] HOME_X_Q = 20'(HOME_X * 1024);
  localparam logic [19:0] HOME_Y_Q = 20'(HOME_Y * 1024);
  localparam logic [19:0] MAX_X_Q  = 20'(MAX_X * 1024);
  localparam logic [19:0] MAX_Y_Q  = 20'(MAX_Y * 1024);
  localparam logic signed [21:0] MAX_X_S = 22'(MAX_X * 1024);
  localparam logic signed [21:0] MAX_Y_S = 22'(MAX_Y * 1024);

  localparam logic [9:0] BORDER_X = 10'(MAX_X);
  localparam logic [9:0] BORDER_Y = 10'(MAX_Y);

  localparam logic [15:0] CD_LAST   = 16'(DELAY_TICKS - 1);
  localparam logic [15:0] DASH_LAST = 16'(MAX_DASH_TICKS - 1);

  state_t             r_state;
  logic [25:0]        r_tick_cnt;
  logic               r_motion_tick;
  logic               r_dash_start;
  logic [15:0]        r_cd_cnt;
  logic [15:0]        r_dash_cnt;
  logic [19:0]        r_pos_x;
  logic [19:0]        r_pos_y;
  logic signed [21:0] r_vel_x;
  logic signed [21:0] r_vel_y;

  // ---------------------------------------------------------------------------
  // Tick divider. Once the offset eats the whole period the tick fires every
  // clk. The ">=" compare lets a shortened period take effect mid-count
  // instead of running the counter past the new terminal value.
  // ---------------------------------------------------------------------------
  logic [25:0] w_period;
  logic        w_wrap;

  assign w_period = (bus.i_speed_offset >= TICK_SAT) ? 26'd1
                                                     : TICK_PERIOD - bus.i_speed_offset;
  assign w_wrap   = (r_tick_cnt >= (w_period - 26'd1));

  // ---------------------------------------------------------------------------
  // Aim: 11-bit signed distance to the player, scaled into Q10.10 velocity.
  // ---------------------------------------------------------------------------
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic signed [21:0] w_dx_ext;
  logic signed [21:0] w_dy_ext;
  logic signed [21:0] w_vel_x;
  logic signed [21:0] w_vel_y;
  logic               w_no_move;

  assign w_dx      = $signed({1'b0, bus.i_player_x}) - $signed({1'b0, r_pos_x[19:10]});
  assign w_dy      = $signed({1'b0, bus.i_player_y}) - $signed({1'b0, r_pos_y[19:10]});
  assign w_dx_ext  = {{11{w_dx[10]}}, w_dx};
  assign w_dy_ext  = {{11{w_dy[10]}}, w_dy};
  assign w_vel_x   = w_dx_ext <<< VEL_SHIFT;
  assign w_vel_y   = w_dy_ext <<< VEL_SHIFT;
  assign w_no_move = (w_dx == 11'sd0) && (w_dy == 11'sd0);

  // ---------------------------------------------------------------------------
  // Dash step: add velocity in 22-bit signed space, then clamp to the
  // playfield. Landing exactly on an edge is not a clamp; only overshoot is.
  // ---------------------------------------------------------------------------
  logic signed [21:0] w_sum_x;
  logic signed [21:0] w_sum_y;
  logic               w_lo_x;
  logic               w_hi_x;
  logic               w_lo_y;
  logic               w_hi_y;
  logic               w_hit;
  logic [19:0]        w_next_x;
  logic [19:0]        w_next_y;

  assign w_sum_x = $signed({2'b00, r_pos_x}) + r_vel_x;
  assign w_sum_y = $signed({2'b00, r_pos_y}) + r_vel_y;
  assign w_lo_x  = (w_sum_x < 22'sd0);
  assign w_hi_x  = (w_sum_x > MAX_X_S);
  assign w_lo_y  = (w_sum_y < 22'sd0);
  assign w_hi_y  = (w_sum_y > MAX_Y_S);
  assign w_hit   = w_lo_x | w_hi_x | w_lo_y | w_hi_y;

  assign w_next_x = w_lo_x ? 20'd0 : (w_hi_x ? MAX_X_Q : w_sum_x[19:0]);
  assign w_next_y = w_lo_y ? 20'd0 : (w_hi_y ? MAX_Y_Q : w_sum_y[19:0]);

  // ---------------------------------------------------------------------------
  // Sequencer. The tick pulse is registered, so every tick-driven action
  // happens on the edge that closes the clk in which o_motion_tick is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_tick_cnt    <= 26'd0;
      r_motion_tick <= 1'b0;
      r_dash_start  <= 1'b0;
      r_cd_cnt      <= 16'd0;
      r_dash_cnt    <= 16'd0;
      r_pos_x       <= HOME_X_Q;
      r_pos_y       <= HOME_Y_Q;
      r_vel_x       <= 22'sd0;
      r_vel_y       <= 22'sd0;
    end else begin
      r_dash_start  <= 1'b0;
      r_motion_tick <= w_wrap;
      if (w_wrap) begin
        r_tick_cnt <= 26'd0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 26'd1;
      end

      // Dropping enable beats any tick-driven transition in the same clk.
      if (!bus.i_enable) begin
        r_state <= ST_IDLE;
        r_vel_x <= 22'sd0;
        r_vel_y <= 22'sd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_COOLDOWN;
            r_cd_cnt <= 16'd0;
          end

          ST_COOLDOWN: begin
            if (r_motion_tick) begin
              if (r_cd_cnt == CD_LAST) begin
                r_state <= ST_AIM;
              end else begin
                r_cd_cnt <= r_cd_cnt + 16'd1;
              end
            end
          end

          ST_AIM: begin
            if (w_no_move) begin
              r_state  <= ST_COOLDOWN;
              r_cd_cnt <= 16'd0;
              r_vel_x  <= 22'sd0;
              r_vel_y  <= 22'sd0;
            end else begin
              r_state      <= ST_DASH;
              r_dash_start <= 1'b1;
              r_dash_cnt   <= 16'd0;
              r_vel_x      <= w_vel_x;
              r_vel_y      <= w_vel_y;
            end
          end

          ST_DASH: begin
            if (r_motion_tick) begin
              r_pos_x <= w_next_x;
              r_pos_y <= w_next_y;
              // Border hit and timeout on the same tick give one exit.
              if (w_hit || (r_dash_cnt == DASH_LAST)) begin
                r_state  <= ST_COOLDOWN;
                r_cd_cnt <= 16'd0;
                r_vel_x  <= 22'sd0;
                r_vel_y  <= 22'sd0;
              end else begin
                r_dash_cnt <= r_dash_cnt + 16'd1;
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_moon_x      = r_pos_x[19:10];
  assign bus.o_moon_y      = r_pos_y[19:10];
  assign bus.o_state       = r_state;
  assign bus.o_dash_start  = r_dash_start;
  assign bus.o_motion_tick = r_motion_tick;
  assign bus.o_on_border   = (bus.o_moon_x == 10'd0) || (bus.o_moon_x == BORDER_X) ||
                             (bus.o_moon_y == 10'd0) || (bus.o_moon_y == BORDER_Y);

endmodule

// File: tb/tb_moon_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_moon_motion_ctrl
//   Directed bench for moon_motion_ctrl with TICK_MAX=4, DELAY_TICKS=3.
//   Dash trajectories are checked from a table of {ticks to advance,
//   expected moon_x, moon_y, state, on_border}; the multi-cycle corners
//   (aim, enable drop, reset mid-dash, tick period) are hand-written.
// -----------------------------------------------------------------------------
module tb_moon_motion_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  moon_motion_if bus();

  moon_motion_ctrl #(
    .MAX_X(384), .MAX_Y(448), .HOME_X(192), .HOME_Y(100),
    .TICK_MAX(4), .DELAY_TICKS(3), .STEP_SHIFT(6), .MAX_DASH_TICKS(255)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  typedef struct {
    int ticks;
    int x;
    int y;
    int st;
    int brd;
  } vec_t;

  vec_t rows [9];

  int n_pass  = 0;
  int n_total = 0;

  int n_dash_start = 0;
  int n_cd_entry   = 0;
  logic [1:0] prev_state = 2'd0;

  // Sampled on the rising edge, i.e. the values that were stable since the
  // preceding falling edge where the main sequence looks at them.
  always @(posedge clk) begin
    if (reset) begin
      prev_state <= 2'd0;
    end else begin
      if (bus.o_dash_start) n_dash_start <= n_dash_start + 1;
      if (bus.o_state == 2'd1 && prev_state != 2'd1) n_cd_entry <= n_cd_entry + 1;
      prev_state <= bus.o_state;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Apply exactly one motion tick: stop at the falling edge where the tick
  // is high (not yet consumed), then step past the edge that consumes it.
  task automatic tick_step();
    int n;
    n = 0;
    while (!bus.o_motion_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_motion_tick) begin
      n_total++;
      $display("FAIL tick_wait: no motion_tick within %0d clks", n);
    end
    @(negedge clk);
  endtask

  task automatic measure_period(output int p);
    int n;
    n = 0;
    while (!bus.o_motion_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    p = 0;
    do begin
      @(negedge clk);
      p++;
    end while (!bus.o_motion_tick && p < 100);
  endtask

  task automatic wait_dash(input string name);
    int n;
    n = 0;
    while (bus.o_state != 2'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.o_state), 3);
  endtask

  task automatic chk_pos(input string name, input int x, input int y);
    chk({name, "_x"}, int'(bus.o_moon_x), x);
    chk({name, "_y"}, int'(bus.o_moon_y), y);
  endtask

  task automatic run_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      for (int t = 0; t < rows[r].ticks; t++) tick_step();
      chk($sformatf("row%0d_x", r),      int'(bus.o_moon_x),    rows[r].x);
      chk($sformatf("row%0d_y", r),      int'(bus.o_moon_y),    rows[r].y);
      chk($sformatf("row%0d_state", r),  int'(bus.o_state),     rows[r].st);
      chk($sformatf("row%0d_border", r), int'(bus.o_on_border), rows[r].brd);
    end
  endtask

  initial begin
    int p;
    int c0;

    // Dash toward (192,300) from (192,100): vel_y = 200<<4 = 3200 per tick.
    rows[0] = '{ticks: 1,  x: 192, y: 103, st: 3, brd: 0};
    rows[1] = '{ticks: 63, x: 192, y: 300, st: 3, brd: 0};
    rows[2] = '{ticks: 47, x: 192, y: 446, st: 3, brd: 0};
    rows[3] = '{ticks: 1,  x: 192, y: 448, st: 1, brd: 1};
    rows[4] = '{ticks: 1,  x: 192, y: 448, st: 1, brd: 1};
    // Dash toward (0,0) from (192,448): vel = (-3072, -7168).
    rows[5] = '{ticks: 1,  x: 189, y: 441, st: 3, brd: 0};
    rows[6] = '{ticks: 31, x: 96,  y: 224, st: 3, brd: 0};
    rows[7] = '{ticks: 32, x: 0,   y: 0,   st: 3, brd: 1};
    rows[8] = '{ticks: 1,  x: 0,   y: 0,   st: 1, brd: 1};

    reset              = 1'b1;
    bus.i_enable       = 1'b0;
    bus.i_player_x     = 10'd0;
    bus.i_player_y     = 10'd0;
    bus.i_speed_offset = 26'd0;
    repeat (3) @(negedge clk);

    chk("rst_state", int'(bus.o_state), 0);
    chk_pos("rst", 192, 100);
    chk("rst_tick", int'(bus.o_motion_tick), 0);
    chk("rst_dash_start", int'(bus.o_dash_start), 0);
    chk("rst_border", int'(bus.o_on_border), 0);

    reset = 1'b0;
    measure_period(p);
    chk("period_off0", p, 4);
    bus.i_speed_offset = 26'd2;
    measure_period(p);
    chk("period_off2", p, 2);
    bus.i_speed_offset = 26'd3;
    measure_period(p);
    chk("period_off3", p, 1);
    bus.i_speed_offset = 26'd0;
    measure_period(p);
    chk("period_back", p, 4);
    chk("idle_hold", int'(bus.o_state), 0);

    // Case 1: enable -> COOLDOWN, AIM on the third tick, no motion.
    bus.i_player_x = 10'd192;
    bus.i_player_y = 10'd300;
    bus.i_enable   = 1'b1;
    @(negedge clk);
    chk("en_cooldown", int'(bus.o_state), 1);
    tick_step();
    chk("cd_tick1", int'(bus.o_state), 1);
    tick_step();
    chk("cd_tick2", int'(bus.o_state), 1);
    tick_step();
    chk("cd_tick3_aim", int'(bus.o_state), 2);
    chk_pos("aim1", 192, 100);

    // Case 2/3: dash down to the bottom border.
    @(negedge clk);
    chk("dash1_state", int'(bus.o_state), 3);
    chk("dash1_start", int'(bus.o_dash_start), 1);
    @(negedge clk);
    chk("dash1_start_low", int'(bus.o_dash_start), 0);
    run_rows(0, 4);
    chk("dash_start_count1", n_dash_start, 1);

    // Case 4: corner dash, both axes clamp on the same tick.
    bus.i_player_x = 10'd0;
    bus.i_player_y = 10'd0;
    tick_step();
    chk("cd2_tick2", int'(bus.o_state), 1);
    tick_step();
    chk("cd2_aim", int'(bus.o_state), 2);
    @(negedge clk);
    chk("dash2_state", int'(bus.o_state), 3);
    chk("dash2_start", int'(bus.o_dash_start), 1);
    c0 = n_cd_entry;
    run_rows(5, 8);
    @(negedge clk);
    chk("corner_single_entry", n_cd_entry - c0, 1);

    // Case 5: player on the moon -> AIM returns to COOLDOWN, no dash.
    tick_step();
    tick_step();
    tick_step();
    chk("aim3_state", int'(bus.o_state), 2);
    @(negedge clk);
    chk("aim3_back_cd", int'(bus.o_state), 1);
    chk("aim3_no_start", int'(bus.o_dash_start), 0);
    @(negedge clk);
    chk("dash_start_count2", n_dash_start, 2);

    bus.i_speed_offset = 26'h3FFFFFF;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fast_tick%0d", k), int'(bus.o_motion_tick), 1);
      @(negedge clk);
    end

    // Case 6: enable drop mid-dash, then reset mid-dash. 1 px per clk.
    bus.i_player_x = 10'd64;
    bus.i_player_y = 10'd64;
    wait_dash("dash3_reached");
    chk("dash3_start", int'(bus.o_dash_start), 1);
    chk_pos("dash3_t0", 0, 0);
    repeat (5) tick_step();
    chk_pos("dash3_t5", 5, 5);
    bus.i_enable = 1'b0;
    @(negedge clk);
    chk("drop_idle", int'(bus.o_state), 0);
    chk_pos("drop", 5, 5);
    repeat (5) @(negedge clk);
    chk_pos("drop_hold", 5, 5);

    bus.i_enable = 1'b1;
    wait_dash("dash4_reached");
    repeat (3) tick_step();
    chk_pos("dash4_t3", 7, 7);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_state", int'(bus.o_state), 0);
    chk_pos("rst2", 192, 100);
    chk("rst2_tick", int'(bus.o_motion_tick), 0);
    repeat (3) @(negedge clk);
    bus.i_enable = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_state", int'(bus.o_state), 0);
    chk_pos("post_rst", 192, 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
